// File: rtl/adxl362_spi_master_pkg.sv
// Shared constants for the ADXL362 SPI master: FSM encodings,
// accelerometer command/register codes and counter sizing helpers.
package adxl362_spi_master_pkg;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_SETUP = 3'd1;
  localparam spi_state_t ST_SHIFT = 3'd2;
  localparam spi_state_t ST_NEXT  = 3'd3;
  localparam spi_state_t ST_HOLD  = 3'd4;
  localparam spi_state_t ST_GAP   = 3'd5;

  localparam logic [7:0] WRITE_REG = 8'h0A;
  localparam logic [7:0] READ_REG  = 8'h0B;
  localparam logic [7:0] READ_FIFO = 8'h0D;

  localparam logic [7:0] DEVID_AD  = 8'h00;
  localparam logic [7:0] XDATA_L   = 8'h0E;
  localparam logic [7:0] POWER_CTL = 8'h2D;

  localparam logic [7:0] DEVID_VAL = 8'hAD;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_w(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/adxl362_spi_master_if.sv
// Byte-stream handshake between register-access logic and the
// SPI master: tx bytes in, received bytes out.
interface adxl362_spi_master_if;

  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;

  modport master (
    output tx_valid_i,
    output tx_data_i,
    output tx_last_i,
    input  tx_ready_o,
    input  rx_valid_o,
    input  rx_data_o
  );

  modport slave (
    input  tx_valid_i,
    input  tx_data_i,
    input  tx_last_i,
    output tx_ready_o,
    output rx_valid_o,
    output rx_data_o
  );

endinterface

// File: rtl/spi_tick_gen.sv
// SCK half-period counter: emits rise/fall enables every CLK_DIV
// cycles while enabled, always starting with the low phase.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int W = $clog2(CLK_DIV) + 1;

  logic [W-1:0] cnt;
  logic         phase;
  logic         term;

  assign term   = (cnt == W'(CLK_DIV - 1));
  assign rise_o = en_i & term & ~phase;
  assign fall_o = en_i & term & phase;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (term) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master framing a byte stream under one chip-select
// assertion; every shifted byte is returned on the rx side.
module adxl362_spi_master
  import adxl362_spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  adxl362_spi_master_if.slave  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sck_o,
  output logic                 ncs_o,
  output logic                 mosi_o,
  input  logic                 miso_i
);

  localparam int CW = cnt_w(CLK_DIV, CS_SETUP, CS_IDLE);

  spi_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          last_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;
  logic          accept;
  logic          rise;
  logic          fall;
  logic          shifting;

  assign bus.tx_ready_o = (state == ST_IDLE) || (state == ST_NEXT);
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.rx_data_o  = rx_data_q;
  assign accept   = bus.tx_valid_i & bus.tx_ready_o;
  assign busy_o   = (state != ST_IDLE);
  assign mosi_o   = tx_sh[7];
  assign shifting = (state == ST_SHIFT);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (shifting),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      done_o     <= 1'b0;
      ncs_o      <= 1'b1;
      sck_o      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_sh   <= bus.tx_data_i;
            last_q  <= bus.tx_last_i;
            bit_cnt <= '0;
            cnt     <= '0;
            ncs_o   <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rise) begin
            sck_o <= 1'b1;
            rx_sh <= {rx_sh[6:0], miso_i};
          end else if (fall) begin
            sck_o <= 1'b0;
            if (bit_cnt == 3'd7) begin
              bit_cnt    <= '0;
              rx_data_q  <= rx_sh;
              rx_valid_q <= 1'b1;
              state      <= last_q ? ST_HOLD : ST_NEXT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end
          end
        end
        ST_NEXT: begin
          if (accept) begin
            tx_sh   <= bus.tx_data_i;
            last_q  <= bus.tx_last_i;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt   <= '0;
            ncs_o <= 1'b1;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CW'(CS_IDLE - 1)) begin
            cnt    <= '0;
            tx_sh  <= '0;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ncs_o <= 1'b1;
          sck_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
